// File: rtl/comp_fiber_pkg.sv
// Shared types and constants for the comparator fiber receive path.
// Holds the frame constants, the aligner state encoding and the 48-step PRBS advance.
package comp_fiber_pkg;

    localparam logic [7:0] K28_5       = 8'hBC;
    localparam int         FRAME_WORDS = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    // One frame's worth of Fibonacci LFSR steps, taps 48,47,21,20.
    function automatic logic [47:0] prbs48_next48(input logic [47:0] x);
        logic [47:0] s;
        s = x;
        for (int i = 0; i < 48; i++) begin
            s = {s[46:0], s[47] ^ s[46] ^ s[20] ^ s[19]};
        end
        return s;
    endfunction

endpackage

// File: rtl/comp_frame_aligner.sv
// Comma aligner: hunts for K28.5, confirms LOCK_FRAMES frames, drops lock after 2 misses.
// State, phase and CEW are registered one cycle behind the comma word; no backpressure.
module comp_frame_aligner
    import comp_fiber_pkg::*;
#(
    parameter int LOCK_FRAMES = 4
) (
    input  logic         comp_clk,
    input  logic         trg_rst,
    input  logic         comma,
    output align_state_t state,
    output logic [1:0]   ph,
    output logic [3:0]   cew
);

    localparam int CW = $clog2(LOCK_FRAMES + 1);

    align_state_t  state_n;
    logic [1:0]    ph_n;
    logic [CW-1:0] good_cnt, good_cnt_n, good_inc;
    logic          bad_cnt, bad_cnt_n;
    logic          hit, miss;

    assign hit      = comma && (ph == 2'd0);
    assign miss     = (comma && (ph != 2'd0)) || (!comma && (ph == 2'd0));
    assign good_inc = good_cnt + CW'(1);

    always_ff @(posedge comp_clk) begin
        if (trg_rst) begin
            state    <= HUNT;
            ph       <= 2'd0;
            good_cnt <= '0;
            bad_cnt  <= 1'b0;
        end else begin
            state    <= state_n;
            ph       <= ph_n;
            good_cnt <= good_cnt_n;
            bad_cnt  <= bad_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        ph_n       = ph + 2'd1;
        good_cnt_n = good_cnt;
        bad_cnt_n  = bad_cnt;
        case (state)
            HUNT: begin
                if (comma) begin
                    // The comma defines ph=0 now, so the next word is ph=1.
                    ph_n       = 2'd1;
                    good_cnt_n = CW'(1);
                    bad_cnt_n  = 1'b0;
                    state_n    = (LOCK_FRAMES <= 1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (miss) begin
                    state_n    = HUNT;
                    good_cnt_n = '0;
                end else if (hit) begin
                    good_cnt_n = good_inc;
                    if (good_inc == CW'(LOCK_FRAMES)) begin
                        state_n   = LOCKED;
                        bad_cnt_n = 1'b0;
                    end
                end
            end
            LOCKED: begin
                if (hit) begin
                    bad_cnt_n = 1'b0;
                end else if (miss) begin
                    if (bad_cnt) begin
                        state_n    = HUNT;
                        bad_cnt_n  = 1'b0;
                        good_cnt_n = '0;
                    end else begin
                        bad_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n    = HUNT;
                good_cnt_n = '0;
                bad_cnt_n  = 1'b0;
            end
        endcase
    end

    always_comb begin
        cew = '0;
        if (state != HUNT) begin
            cew[ph] = 1'b1;
        end
    end

endmodule

// File: rtl/comp_fiber_rx_core.sv
// Comparator fiber RX framer/checker: aligns K28.5 frames, unpacks 48-bit payload, checks PRBS.
// Payload valid one cycle after w3 is registered; MATCH updates on the comma edge; no backpressure.
module comp_fiber_rx_core
    import comp_fiber_pkg::*;
#(
    parameter int SIM_SPEEDUP   = 0,
    parameter int USE_CHIPSCOPE = 0,
    parameter int LOCK_FRAMES   = 4
) (
    input  logic        comp_clk,
    input  logic        trg_rst,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_charisk,
    input  logic        rx_resetdone,
    input  logic        cmp_sigdet,
    output logic        cmp_sd,
    output logic        cmp_tdis,
    output logic [47:0] rcv_data,
    output logic        cew0,
    output logic        cew1,
    output logic        cew2,
    output logic        cew3,
    output logic        valid,
    output logic        match,
    output logic        strt_mtch,
    output logic        ltncy_trig,
    output logic        rx_sync_done
);

    localparam int SYNC_BITS = (SIM_SPEEDUP != 0) ? 4 : 12;

    if (USE_CHIPSCOPE != 0) begin : g_chipscope_stub
    end

    logic [15:0]        rx_data_q;
    logic [1:0]         rx_isk_q;
    logic               comma;
    align_state_t       state;
    logic [1:0]         ph;
    logic [3:0]         cew;
    logic [47:0]        lfsr, lfsr_exp;
    logic [SYNC_BITS:0] sync_cnt;
    logic               sd_meta;

    always_ff @(posedge comp_clk) begin
        if (trg_rst) begin
            rx_data_q <= '0;
            rx_isk_q  <= '0;
        end else begin
            rx_data_q <= rx_data;
            rx_isk_q  <= rx_charisk;
        end
    end

    assign comma = (rx_isk_q == 2'b01) && (rx_data_q[7:0] == K28_5);

    comp_frame_aligner #(
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_aligner (
        .comp_clk (comp_clk),
        .trg_rst  (trg_rst),
        .comma    (comma),
        .state    (state),
        .ph       (ph),
        .cew      (cew)
    );

    assign valid = (state == LOCKED);
    assign cew0  = cew[0];
    assign cew1  = cew[1];
    assign cew2  = cew[2];
    assign cew3  = cew[3];

    always_ff @(posedge comp_clk) begin
        if (trg_rst) begin
            rcv_data <= '0;
        end else begin
            if (cew[1]) rcv_data[15:0]  <= rx_data_q;
            if (cew[2]) rcv_data[31:16] <= rx_data_q;
            if (cew[3]) rcv_data[47:32] <= rx_data_q;
        end
    end

    assign lfsr_exp = prbs48_next48(lfsr);

    // At the ph=0 edge rcv_data holds the complete previous frame.
    always_ff @(posedge comp_clk) begin
        if (trg_rst) begin
            lfsr       <= '0;
            strt_mtch  <= 1'b1;
            match      <= 1'b0;
            ltncy_trig <= 1'b0;
        end else begin
            ltncy_trig <= 1'b0;
            if (!valid) begin
                strt_mtch <= 1'b1;
                match     <= 1'b0;
            end else if (cew[0]) begin
                if (strt_mtch) begin
                    lfsr       <= rcv_data;
                    strt_mtch  <= 1'b0;
                    ltncy_trig <= 1'b1;
                    match      <= 1'b1;
                end else begin
                    lfsr  <= lfsr_exp;
                    match <= (rcv_data == lfsr_exp);
                end
            end
        end
    end

    // Independent of trg_rst: the link reset is generated from rx_sync_done.
    always_ff @(posedge comp_clk) begin
        if (!rx_resetdone) begin
            sync_cnt <= '0;
        end else if (!sync_cnt[SYNC_BITS]) begin
            sync_cnt <= sync_cnt + {{SYNC_BITS{1'b0}}, 1'b1};
        end
    end

    assign rx_sync_done = sync_cnt[SYNC_BITS];

    always_ff @(posedge comp_clk) begin
        if (trg_rst) begin
            sd_meta <= 1'b0;
            cmp_sd  <= 1'b0;
        end else begin
            sd_meta <= cmp_sigdet;
            cmp_sd  <= sd_meta;
        end
    end

    assign cmp_tdis = 1'b0;

endmodule

// File: tb/tb_comp_fiber_rx_core.sv
// Directed bench for comp_fiber_rx_core: sync settle, lock, PRBS seed/check, loss of lock, reset.
module tb_comp_fiber_rx_core;

    logic        comp_clk = 1'b0;
    logic        trg_rst;
    logic [15:0] rx_data;
    logic [1:0]  rx_charisk;
    logic        rx_resetdone;
    logic        cmp_sigdet;
    logic        cmp_sd, cmp_tdis;
    logic [47:0] rcv_data;
    logic        cew0, cew1, cew2, cew3;
    logic        valid, match, strt_mtch, ltncy_trig, rx_sync_done;

    int tests = 0;
    int fails = 0;
    int trig_cnt = 0;

    localparam logic [47:0] SEED = 48'h123456789ABC;
    logic [47:0] pay, p4, p5;

    always #5 comp_clk = ~comp_clk;

    comp_fiber_rx_core #(
        .SIM_SPEEDUP   (1),
        .USE_CHIPSCOPE (0),
        .LOCK_FRAMES   (4)
    ) dut (
        .comp_clk     (comp_clk),
        .trg_rst      (trg_rst),
        .rx_data      (rx_data),
        .rx_charisk   (rx_charisk),
        .rx_resetdone (rx_resetdone),
        .cmp_sigdet   (cmp_sigdet),
        .cmp_sd       (cmp_sd),
        .cmp_tdis     (cmp_tdis),
        .rcv_data     (rcv_data),
        .cew0         (cew0),
        .cew1         (cew1),
        .cew2         (cew2),
        .cew3         (cew3),
        .valid        (valid),
        .match        (match),
        .strt_mtch    (strt_mtch),
        .ltncy_trig   (ltncy_trig),
        .rx_sync_done (rx_sync_done)
    );

    function automatic logic [47:0] model_next(input logic [47:0] v);
        logic [47:0] r;
        logic        fb;
        r = v;
        repeat (48) begin
            fb   = r[47] ^ r[46] ^ r[20] ^ r[19];
            r    = r << 1;
            r[0] = fb;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [15:0] d, input logic [1:0] k);
        rx_data    = d;
        rx_charisk = k;
        @(posedge comp_clk);
        #1;
        trig_cnt += int'(ltncy_trig);
    endtask

    task automatic send_frame(input logic [47:0] p, input bit drop, input bit corrupt);
        if (drop) put(16'h0000, 2'b00);
        else      put(16'h00BC, 2'b01);
        put(p[15:0], 2'b00);
        put(corrupt ? (p[31:16] ^ 16'h0001) : p[31:16], 2'b00);
        put(p[47:32], 2'b00);
    endtask

    initial begin
        trg_rst      = 1'b1;
        rx_resetdone = 1'b0;
        cmp_sigdet   = 1'b0;
        rx_data      = '0;
        rx_charisk   = '0;
        repeat (3) put(16'h0000, 2'b00);

        chk("rst_valid", 48'(valid), 48'd0);
        chk("rst_cew", 48'({cew3, cew2, cew1, cew0}), 48'd0);
        chk("rst_strt", 48'(strt_mtch), 48'd1);
        chk("rst_match", 48'(match), 48'd0);
        chk("rst_trig", 48'(ltncy_trig), 48'd0);
        chk("rst_rcv", rcv_data, 48'd0);
        chk("tdis", 48'(cmp_tdis), 48'd0);
        chk("rst_sd", 48'(cmp_sd), 48'd0);

        // Settle counter runs while trg_rst is still asserted.
        rx_resetdone = 1'b1;
        repeat (15) put(16'h0000, 2'b00);
        chk("sync_15", 48'(rx_sync_done), 48'd0);
        put(16'h0000, 2'b00);
        chk("sync_16", 48'(rx_sync_done), 48'd1);

        trg_rst    = 1'b0;
        cmp_sigdet = 1'b1;
        put(16'h0000, 2'b00);
        chk("sd_1", 48'(cmp_sd), 48'd0);
        put(16'h0000, 2'b00);
        chk("sd_2", 48'(cmp_sd), 48'd1);
        chk("hunt_cew", 48'({cew3, cew2, cew1, cew0}), 48'd0);

        send_frame(48'h111111111111, 1'b0, 1'b0);
        chk("f1_cew", 48'({cew3, cew2, cew1, cew0}), 48'b1000);

        put(16'h00BC, 2'b01);
        chk("f2_cew0", 48'({cew3, cew2, cew1, cew0}), 48'b0001);
        put(16'h2222, 2'b00);
        chk("f2_cew1", 48'({cew3, cew2, cew1, cew0}), 48'b0010);
        put(16'h2222, 2'b00);
        chk("f2_cew2", 48'({cew3, cew2, cew1, cew0}), 48'b0100);
        put(16'h2222, 2'b00);
        chk("f2_cew3", 48'({cew3, cew2, cew1, cew0}), 48'b1000);

        send_frame(48'h333333333333, 1'b0, 1'b0);
        chk("f3_valid", 48'(valid), 48'd0);

        p4 = SEED;
        send_frame(p4, 1'b0, 1'b0);
        chk("f4_valid", 48'(valid), 48'd1);
        chk("f4_strt", 48'(strt_mtch), 48'd1);
        chk("f4_trig", 48'(trig_cnt), 48'd0);

        p5 = model_next(p4);
        send_frame(p5, 1'b0, 1'b0);
        chk("f5_strt", 48'(strt_mtch), 48'd0);
        chk("f5_trig", 48'(trig_cnt), 48'd1);
        chk("f5_match", 48'(match), 48'd1);
        chk("f5_rcv", rcv_data, {p4[47:32], p5[31:0]});

        pay = model_next(p5);
        send_frame(pay, 1'b0, 1'b0);
        chk("f6_match", 48'(match), 48'd1);
        pay = model_next(pay);
        send_frame(pay, 1'b0, 1'b1);
        chk("f7_match", 48'(match), 48'd1);
        pay = model_next(pay);
        send_frame(pay, 1'b0, 1'b0);
        chk("f8_match_bad", 48'(match), 48'd0);
        chk("f8_valid", 48'(valid), 48'd1);
        pay = model_next(pay);
        send_frame(pay, 1'b0, 1'b0);
        chk("f9_match", 48'(match), 48'd1);
        chk("f9_trig", 48'(trig_cnt), 48'd1);

        pay = model_next(pay);
        send_frame(pay, 1'b1, 1'b0);
        chk("f10_valid", 48'(valid), 48'd1);
        pay = model_next(pay);
        send_frame(pay, 1'b1, 1'b0);
        chk("f11_valid", 48'(valid), 48'd0);
        chk("f11_strt", 48'(strt_mtch), 48'd1);
        chk("f11_match", 48'(match), 48'd0);
        chk("f11_cew", 48'({cew3, cew2, cew1, cew0}), 48'd0);

        repeat (3) begin
            pay = model_next(pay);
            send_frame(pay, 1'b0, 1'b0);
        end
        chk("f14_valid", 48'(valid), 48'd0);
        pay = model_next(pay);
        send_frame(pay, 1'b0, 1'b0);
        chk("f15_valid", 48'(valid), 48'd1);
        chk("f15_strt", 48'(strt_mtch), 48'd1);
        pay = model_next(pay);
        send_frame(pay, 1'b0, 1'b0);
        chk("f16_trig", 48'(trig_cnt), 48'd2);
        chk("f16_strt", 48'(strt_mtch), 48'd0);
        pay = model_next(pay);
        send_frame(pay, 1'b0, 1'b0);
        chk("f17_match", 48'(match), 48'd1);

        pay = model_next(pay);
        put(16'h00BC, 2'b01);
        put(pay[15:0], 2'b00);
        put(pay[31:16], 2'b00);
        chk("mid_cew", 48'({cew3, cew2, cew1, cew0}), 48'b0100);
        trg_rst = 1'b1;
        put(pay[47:32], 2'b00);
        chk("mid_rst_cew", 48'({cew3, cew2, cew1, cew0}), 48'd0);
        chk("mid_rst_valid", 48'(valid), 48'd0);
        chk("mid_rst_rcv", rcv_data, 48'd0);
        chk("mid_rst_strt", 48'(strt_mtch), 48'd1);
        chk("mid_rst_match", 48'(match), 48'd0);
        chk("mid_rst_sync", 48'(rx_sync_done), 48'd1);
        trg_rst = 1'b0;
        put(16'h0000, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
